// File: rtl/hue_sequencer.sv
// Colour-wheel sequencer feeding the RGB PWM generators.
// Walks the six HSV hue segments and ramps one channel per segment.
// Duty changes are committed only on PWM frame boundaries.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   enable          - 1 = run, 0 = freeze timer, pending step and outputs
//   frame_sync      - one-cycle pulse at the start of each PWM period
//   duty_r/g/b      - registered channel duties, 0..PWM_INTERVAL
//   segment         - current hue segment, 0..5
//   step_done       - pulses for one cycle after each committed step
//   wrap            - pulses for one cycle after segment 5 advances to 0
module hue_sequencer #(
  parameter int unsigned PWM_INTERVAL = 1200,
  parameter int unsigned STEP_SIZE    = 12,
  parameter int unsigned STEP_CYCLES  = 20000
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable,
  input  logic                                frame_sync,
  output logic [$clog2(PWM_INTERVAL+1)-1:0]   duty_r,
  output logic [$clog2(PWM_INTERVAL+1)-1:0]   duty_g,
  output logic [$clog2(PWM_INTERVAL+1)-1:0]   duty_b,
  output logic [2:0]                          segment,
  output logic                                step_done,
  output logic                                wrap
);

  localparam int unsigned DW = $clog2(PWM_INTERVAL + 1);
  localparam int unsigned EW = DW + 1;
  localparam int unsigned TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [TW-1:0] TC_LAST = TW'(STEP_CYCLES - 1);
  localparam logic [EW-1:0] FULL_E  = EW'(PWM_INTERVAL);
  localparam logic [EW-1:0] STEP_E  = EW'(STEP_SIZE);
  localparam logic [DW-1:0] FULL    = DW'(PWM_INTERVAL);

  typedef enum logic [2:0] {
    SEG0 = 3'd0,
    SEG1 = 3'd1,
    SEG2 = 3'd2,
    SEG3 = 3'd3,
    SEG4 = 3'd4,
    SEG5 = 3'd5
  } seg_t;

  seg_t          seg_q, seg_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pending_q, pending_d;
  logic [DW-1:0] r_d, g_d, b_d;
  logic          done_d, wrap_d;

  logic          tc;
  logic          commit;
  logic          ramp_up;
  logic          at_end;
  logic [DW-1:0] ramp_cur;
  logic [DW-1:0] ramp_nxt;
  logic [EW-1:0] ramp_sum;
  logic [EW-1:0] ramp_dif;

  assign segment = seg_q;

  // Next-state: step timer, pending flag, ramp arithmetic and segment advance
  always_comb begin
    seg_d     = seg_q;
    timer_d   = timer_q;
    pending_d = pending_q;
    r_d       = duty_r;
    g_d       = duty_g;
    b_d       = duty_b;
    done_d    = 1'b0;
    wrap_d    = 1'b0;
    ramp_up   = 1'b0;
    ramp_cur  = '0;
    ramp_nxt  = '0;
    at_end    = 1'b0;

    // Ramping channel and direction for the current segment
    case (seg_q)
      SEG0:    begin ramp_cur = duty_g; ramp_up = 1'b1; end
      SEG1:    begin ramp_cur = duty_r; ramp_up = 1'b0; end
      SEG2:    begin ramp_cur = duty_b; ramp_up = 1'b1; end
      SEG3:    begin ramp_cur = duty_g; ramp_up = 1'b0; end
      SEG4:    begin ramp_cur = duty_r; ramp_up = 1'b1; end
      SEG5:    begin ramp_cur = duty_b; ramp_up = 1'b0; end
      default: begin ramp_cur = '0;     ramp_up = 1'b0; end
    endcase

    // One extra bit of headroom so the saturation tests never see a wrap
    ramp_sum = {1'b0, ramp_cur} + STEP_E;
    ramp_dif = {1'b0, ramp_cur} - STEP_E;
    if (ramp_up) begin
      if (ramp_sum >= FULL_E) begin
        ramp_nxt = FULL;
        at_end   = 1'b1;
      end else begin
        ramp_nxt = ramp_sum[DW-1:0];
      end
    end else begin
      if ({1'b0, ramp_cur} <= STEP_E) begin
        ramp_nxt = '0;
        at_end   = 1'b1;
      end else begin
        ramp_nxt = ramp_dif[DW-1:0];
      end
    end

    tc     = enable && (timer_q == TC_LAST);
    commit = enable && frame_sync && (pending_q || tc);

    if (enable) begin
      timer_d = tc ? '0 : timer_q + TW'(1);
    end

    // A terminal count without a frame edge parks one step; further counts merge
    if (commit) begin
      pending_d = 1'b0;
      done_d    = 1'b1;
      case (seg_q)
        SEG0, SEG3: g_d = ramp_nxt;
        SEG1, SEG4: r_d = ramp_nxt;
        default:    b_d = ramp_nxt;
      endcase
      if (at_end) begin
        seg_d  = (seg_q == SEG5) ? SEG0 : seg_t'(seg_q + 3'd1);
        wrap_d = (seg_q == SEG5);
      end
    end else if (tc) begin
      pending_d = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q     <= SEG0;
      timer_q   <= '0;
      pending_q <= 1'b0;
      duty_r    <= FULL;
      duty_g    <= '0;
      duty_b    <= '0;
      step_done <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      seg_q     <= seg_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      duty_r    <= r_d;
      duty_g    <= g_d;
      duty_b    <= b_d;
      step_done <= done_d;
      wrap      <= wrap_d;
    end
  end

endmodule

// File: tb/tb_hue_sequencer.sv
// Testbench for hue_sequencer: two instances (STEP_SIZE 4 and 5, interval 12,
// step period 5) share stimulus and are compared with a behavioural model.
module tb_hue_sequencer;

  localparam int P   = 12;
  localparam int CYC = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic frame_sync = 1'b0;

  logic [3:0] ra, ga, ba, rb, gb, bb;
  logic [2:0] sa, sb;
  logic       da, wa, db, wb;

  hue_sequencer #(.PWM_INTERVAL(P), .STEP_SIZE(4), .STEP_CYCLES(CYC)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .frame_sync(frame_sync),
    .duty_r(ra), .duty_g(ga), .duty_b(ba), .segment(sa),
    .step_done(da), .wrap(wa)
  );

  hue_sequencer #(.PWM_INTERVAL(P), .STEP_SIZE(5), .STEP_CYCLES(CYC)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .frame_sync(frame_sync),
    .duty_r(rb), .duty_g(gb), .duty_b(bb), .segment(sb),
    .step_done(db), .wrap(wb)
  );

  always #5 clk = ~clk;

  logic [16:0] obs_a, obs_b;
  assign obs_a = {ra, ga, ba, sa, da, wa};
  assign obs_b = {rb, gb, bb, sb, db, wb};

  int checks = 0;
  int passed = 0;

  // Behavioural model: duties indexed [instance][0=R,1=G,2=B]
  int ss[2]      = '{4, 5};
  int ramp_ch[6] = '{1, 0, 2, 1, 0, 2};
  bit ramp_up[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  int m_d[2][3]  = '{'{P, 0, 0}, '{P, 0, 0}};
  int m_seg[2]   = '{0, 0};
  int m_tmr[2]   = '{0, 0};
  bit m_pend[2]  = '{1'b0, 1'b0};
  bit m_done[2]  = '{1'b0, 1'b0};
  bit m_wrap[2]  = '{1'b0, 1'b0};

  always @(posedge clk) begin : model
    int ch;
    int v;
    bit adv;
    bit tc;
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      m_wrap[i] = 1'b0;
      if (rst) begin
        m_d[i][0] = P; m_d[i][1] = 0; m_d[i][2] = 0;
        m_seg[i] = 0; m_tmr[i] = 0; m_pend[i] = 1'b0;
      end else if (enable) begin
        tc = (m_tmr[i] == CYC - 1);
        m_tmr[i] = tc ? 0 : m_tmr[i] + 1;
        if (frame_sync && (m_pend[i] || tc)) begin
          ch = ramp_ch[m_seg[i]];
          if (ramp_up[m_seg[i]]) begin
            v = m_d[i][ch] + ss[i];
            adv = (v >= P);
            if (adv) v = P;
          end else begin
            v = m_d[i][ch] - ss[i];
            adv = (v <= 0);
            if (adv) v = 0;
          end
          m_d[i][ch] = v;
          m_done[i] = 1'b1;
          m_pend[i] = 1'b0;
          if (adv) begin
            if (m_seg[i] == 5) begin
              m_seg[i] = 0;
              m_wrap[i] = 1'b1;
            end else begin
              m_seg[i] = m_seg[i] + 1;
            end
          end
        end else if (tc) begin
          m_pend[i] = 1'b1;
        end
      end
    end
  end

  function automatic logic [16:0] exp_vec(input int i);
    return {4'(m_d[i][0]), 4'(m_d[i][1]), 4'(m_d[i][2]), 3'(m_seg[i]),
            m_done[i], m_wrap[i]};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b1; frame_sync = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs_a !== {4'd12, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0})
      $display("FAIL reset_a: got %h expected %h", obs_a, {4'd12, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0});
    else passed++;
    checks++;
    if (obs_b !== {4'd12, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0})
      $display("FAIL reset_b: got %h expected %h", obs_b, {4'd12, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0});
    else passed++;
  endtask

  task automatic test_first_commits();
    do_reset();
    for (int c = 1; c <= 15; c++) begin
      tick();
      checks++;
      if (da !== ((c % 5) == 0))
        $display("FAIL first_step_done c=%0d: got %b expected %b", c, da, ((c % 5) == 0));
      else passed++;
      if (c == 5) begin
        checks++;
        if (ga !== 4'd4) $display("FAIL first_duty_g: got %0d expected 4", ga);
        else passed++;
      end
    end
    checks++;
    if ({ga, sa} !== {4'd12, 3'd1})
      $display("FAIL seg0_end: got g=%0d seg=%0d expected g=12 seg=1", ga, sa);
    else passed++;
  endtask

  task automatic test_full_wheel();
    int n_done = 0, n_wrap = 0, n_coinc = 0, wrap_at = 0;
    do_reset();
    for (int c = 0; c < 90; c++) begin
      tick();
      if (da) n_done++;
      if (wa) begin n_wrap++; wrap_at = n_done; if (da) n_coinc++; end
    end
    checks++;
    if (n_done != 18) $display("FAIL wheel_commits: got %0d expected 18", n_done);
    else passed++;
    checks++;
    if (n_wrap != 1 || n_coinc != 1 || wrap_at != 18)
      $display("FAIL wheel_wrap: got count=%0d coinc=%0d at=%0d expected 1 1 18", n_wrap, n_coinc, wrap_at);
    else passed++;
    checks++;
    if ({ra, ga, ba, sa} !== {4'd12, 4'd0, 4'd0, 3'd0})
      $display("FAIL wheel_final: got r=%0d g=%0d b=%0d seg=%0d expected 12 0 0 0", ra, ga, ba, sa);
    else passed++;
  endtask

  task automatic test_clamp();
    int exp_g[6] = '{5, 10, 12, 12, 12, 12};
    int exp_r[6] = '{12, 12, 12, 7, 2, 0};
    int exp_s[6] = '{0, 0, 1, 1, 1, 2};
    int k = 0;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      tick();
      if (db) begin
        if (k < 6) begin
          checks++;
          if (gb !== 4'(exp_g[k]) || rb !== 4'(exp_r[k]) || sb !== 3'(exp_s[k]))
            $display("FAIL clamp_step%0d: got g=%0d r=%0d seg=%0d expected g=%0d r=%0d seg=%0d",
                     k, gb, rb, sb, exp_g[k], exp_r[k], exp_s[k]);
          else passed++;
        end
        k++;
      end
    end
    checks++;
    if (k != 6) $display("FAIL clamp_count: got %0d expected 6", k);
    else passed++;
  endtask

  task automatic test_sparse_frames();
    int phase;
    do_reset();
    frame_sync = 1'b0;
    phase = int'($urandom_range(0, 6));
    for (int c = 0; c < 210; c++) begin
      frame_sync = ((c % 7) == phase);
      tick();
      checks++;
      if (obs_a !== exp_vec(0)) $display("FAIL sparse_a c=%0d: got %h expected %h", c, obs_a, exp_vec(0));
      else passed++;
      checks++;
      if (obs_b !== exp_vec(1)) $display("FAIL sparse_b c=%0d: got %h expected %h", c, obs_b, exp_vec(1));
      else passed++;
      if (da || db) begin
        checks++;
        if (!frame_sync) $display("FAIL sparse_commit_off_frame c=%0d: got step_done=1 expected 0", c);
        else passed++;
      end
    end
  endtask

  task automatic test_enable_freeze();
    do_reset();
    for (int c = 0; c < 35; c++) tick();
    checks++;
    if ({ra, ga, ba, sa} !== {4'd0, 4'd12, 4'd4, 3'd2})
      $display("FAIL freeze_setup: got r=%0d g=%0d b=%0d seg=%0d expected 0 12 4 2", ra, ga, ba, sa);
    else passed++;
    frame_sync = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    enable = 1'b0;
    frame_sync = 1'b1;
    for (int c = 0; c < 22; c++) begin
      tick();
      checks++;
      if (obs_a !== {4'd0, 4'd12, 4'd4, 3'd2, 1'b0, 1'b0})
        $display("FAIL freeze_hold c=%0d: got %h expected %h", c, obs_a, {4'd0, 4'd12, 4'd4, 3'd2, 1'b0, 1'b0});
      else passed++;
    end
    enable = 1'b1;
    tick();
    checks++;
    if (ba !== 4'd8 || da !== 1'b1)
      $display("FAIL freeze_resume: got b=%0d done=%b expected b=8 done=1", ba, da);
    else passed++;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (da !== (c == 4)) $display("FAIL freeze_timer c=%0d: got %b expected %b", c, da, (c == 4));
      else passed++;
    end
    checks++;
    if ({ba, sa} !== {4'd12, 3'd3})
      $display("FAIL freeze_seg2_end: got b=%0d seg=%0d expected 12 3", ba, sa);
    else passed++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int c = 0; c < 50; c++) tick();
    checks++;
    if ({ga, sa} !== {4'd8, 3'd3})
      $display("FAIL midrst_setup: got g=%0d seg=%0d expected 8 3", ga, sa);
    else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (obs_a !== {4'd12, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0})
      $display("FAIL midrst_values: got %h expected %h", obs_a, {4'd12, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0});
    else passed++;
    for (int c = 1; c <= 5; c++) begin
      tick();
      checks++;
      if (da !== (c == 5)) $display("FAIL midrst_timer c=%0d: got %b expected %b", c, da, (c == 5));
      else passed++;
    end
    checks++;
    if (ga !== 4'd4) $display("FAIL midrst_first_g: got %0d expected 4", ga);
    else passed++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 199) == 0);
      enable     = ($urandom_range(0, 9) != 0);
      frame_sync = ($urandom_range(0, 2) == 0);
      tick();
      checks++;
      if (obs_a !== exp_vec(0)) $display("FAIL random_a c=%0d: got %h expected %h", c, obs_a, exp_vec(0));
      else passed++;
      checks++;
      if (obs_b !== exp_vec(1)) $display("FAIL random_b c=%0d: got %h expected %h", c, obs_b, exp_vec(1));
      else passed++;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_first_commits();
    test_full_wheel();
    test_clamp();
    test_sparse_frames();
    test_enable_freeze();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
